// File: rtl/uart_rx_osv.sv
// -----------------------------------------------------------------------------
// uart_rx_osv
//   Oversampling UART receiver for 8N1 frames, LSB first. The serial line is
//   sampled on a shared oversample strobe (b_tick, OSV_RATE strobes per bit).
//   Each recovered byte is presented on rx_data with a single-cycle rx_done.
//
// Parameters
//   DATA_WIDTH  data bits per frame (<= 8); narrower data is right-aligned
//   OSV_RATE    b_tick strobes per bit period (even, >= 4)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   b_tick     1-cycle oversample strobe
//   rx         asynchronous serial input, idle high
//   rx_data    last good byte, held until the next accepted frame
//   rx_done    1-cycle pulse, rx_data valid in the same cycle
//   rx_busy    high while a frame is in progress (START/DATA/STOP)
//   frame_err  1-cycle pulse on a bad stop bit (only with UART_RX_FRAME_ERR_EN)
//
// Optional feature
//   UART_RX_FRAME_ERR_EN : when defined, the stop bit is checked and a bad
//   stop bit raises frame_err instead of rx_done. When undefined, the port
//   does not exist and every completed frame is accepted.
// -----------------------------------------------------------------------------
module uart_rx_osv #(
  parameter int DATA_WIDTH = 8,
  parameter int OSV_RATE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int TICK_W = $clog2(OSV_RATE);
  localparam int ALIGN  = 8 - DATA_WIDTH;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OSV_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSV_RATE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic              rx_meta;
  logic              rx_s;
  logic [1:0]        state;
  logic [TICK_W-1:0] tickcnt;
  logic [2:0]        bitcnt;
  logic [7:0]        shift;

  // Two-flop synchronizer for the asynchronous rx line. Both flops reset to
  // the idle (high) level so that leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered outputs.
  // The start bit is confirmed at its midpoint; from there every sample is a
  // full bit period apart, landing at mid-bit for data and stop. The frame
  // finishes at mid stop bit so a following start edge is never missed, even
  // with no idle gap between frames. rx_busy tracks "not IDLE" and therefore
  // falls on the same edge that raises rx_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tickcnt <= '0;
      bitcnt  <= '0;
      shift   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_busy <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            tickcnt <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (b_tick) begin
            if (tickcnt == TICK_MID) begin
              tickcnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                // Line went back high before mid start bit: a glitch.
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tickcnt <= tickcnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (b_tick) begin
            if (tickcnt == TICK_LAST) begin
              tickcnt <= '0;
              shift   <= {rx_s, shift[7:1]};
              if (bitcnt == BIT_LAST) begin
                bitcnt <= '0;
                state  <= STOP;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end else begin
              tickcnt <= tickcnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (b_tick) begin
            if (tickcnt == TICK_LAST) begin
              tickcnt <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              // Narrow frames end up in the top of shift; move them down.
`ifdef UART_RX_FRAME_ERR_EN
              if (rx_s) begin
                rx_done <= 1'b1;
                rx_data <= shift >> ALIGN;
              end else begin
                frame_err <= 1'b1;
              end
`else
              rx_done <= 1'b1;
              rx_data <= shift >> ALIGN;
`endif
            end else begin
              tickcnt <= tickcnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          tickcnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_osv.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_osv
//   Self-checking bench for uart_rx_osv (OSV_RATE=16, b_tick every 4 clk).
//   Frames are driven as line levels held for whole bit periods; a monitor
//   records every rx_done / frame_err pulse, and each directed step compares
//   the recorded behaviour against values computed here from the byte sent.
// -----------------------------------------------------------------------------
module tb_uart_rx_osv;

  localparam int DW      = 8;
  localparam int OSV     = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK = OSV * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Monitor state
  int         cyc = 0;
  int         done_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       busy_at_done = 1'b1;
  int         last_done_cyc = 0;
  int         prev_done_cyc = 0;

  logic [1:0] tick_div = 2'd0;

  uart_rx_osv #(
    .DATA_WIDTH(DW),
    .OSV_RATE  (OSV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .b_tick   (b_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Free-running oversample strobe, one clk high out of every four
  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    b_tick   <= (tick_div == 2'd3);
  end

  // Records every output pulse, sampled away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_data     <= rx_data;
      busy_at_done  <= rx_busy;
      prev_done_cyc <= last_done_cyc;
      last_done_cyc <= cyc;
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
`endif
  end

  // Reference: the byte delivered is the DW low bits of what was sent
  function automatic logic [7:0] expectedByte(input logic [7:0] b);
    return 8'((int'(b)) % (1 << DW));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one whole frame on rx. A bad stop bit is held low just past its
  // midpoint and then released, so the receiver sees a short low pulse it
  // rejects as a glitch rather than a new frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_ok,
                               output logic busy_mid);
    rx = 1'b0;
    repeat (BIT_CLK * 3 / 4) @(negedge clk);
    busy_mid = rx_busy;
    repeat (BIT_CLK / 4) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx = data[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (BIT_CLK / 2 + 8) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLK / 2 - 8) @(negedge clk);
    end
  endtask

  // Waits for the next b_tick (bounded) and lands on the following negedge
  task automatic waitTick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b_tick !== 1'b1 && n < 16);
  endtask

  // Behavioural transmitter clocked by the shared b_tick
  task automatic sendLoopback(input logic [7:0] d);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    waitTick();
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (OSV) waitTick();
    end
  endtask

  initial begin
    int         base_done;
    int         base_fe;
    logic       bm;
    logic [7:0] b;
    logic [7:0] v9e;
    int         gap;

    $display("[TB] uart_rx_osv bench start");

    // Reset
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset_rx_done", 32'(rx_done), 32'h0);
    checkOutput("reset_rx_busy", 32'(rx_busy), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
`endif
    repeat (20) @(negedge clk);

    // 1. Single good frame 0x55
    base_done = done_cnt;
    applyStimulus(8'h55, 1'b1, bm);
    repeat (4) @(negedge clk);
    checkOutput("t1_done_count", 32'(done_cnt - base_done), 32'd1);
    checkOutput("t1_rx_data", 32'(last_data), 32'h55);
    checkOutput("t1_busy_mid_start", 32'(bm), 32'h1);
    checkOutput("t1_busy_at_done", 32'(busy_at_done), 32'h0);
    checkOutput("t1_busy_after", 32'(rx_busy), 32'h0);

    // 2. Short low glitch: 5 ticks low, then high
    base_done = done_cnt;
    rx = 1'b0;
    repeat (5 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    checkOutput("t2_no_done", 32'(done_cnt - base_done), 32'd0);
    checkOutput("t2_busy", 32'(rx_busy), 32'h0);
    checkOutput("t2_rx_data_held", 32'(rx_data), 32'h55);

    // 3. Back-to-back 0xA3, 0x0F
    base_done = done_cnt;
    applyStimulus(8'hA3, 1'b1, bm);
    checkOutput("t3_first_data", 32'(last_data), 32'hA3);
    applyStimulus(8'h0F, 1'b1, bm);
    repeat (4) @(negedge clk);
    checkOutput("t3_done_count", 32'(done_cnt - base_done), 32'd2);
    checkOutput("t3_second_data", 32'(last_data), 32'h0F);
    checkOutput("t3_done_spacing", 32'(last_done_cyc - prev_done_cyc),
                32'(10 * BIT_CLK));
    repeat (BIT_CLK) @(negedge clk);

    // 4. 0x3C with a bad stop bit
    base_done = done_cnt;
    base_fe   = fe_cnt;
    applyStimulus(8'h3C, 1'b0, bm);
    repeat (BIT_CLK) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("t4_frame_err", 32'(fe_cnt - base_fe), 32'd1);
    checkOutput("t4_no_done", 32'(done_cnt - base_done), 32'd0);
    checkOutput("t4_rx_data_held", 32'(rx_data), 32'h0F);
`else
    checkOutput("t4_done_count", 32'(done_cnt - base_done), 32'd1);
    checkOutput("t4_rx_data", 32'(last_data), 32'h3C);
`endif
    checkOutput("t4_busy_after", 32'(rx_busy), 32'h0);

    // 5. Reset pulse during data bit 4 of 0x9E, then 0xC8
    base_done = done_cnt;
    v9e = 8'h9E;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = v9e[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = v9e[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("t5_rx_data_reset", 32'(rx_data), 32'h00);
    checkOutput("t5_busy_reset", 32'(rx_busy), 32'h0);
    checkOutput("t5_done_reset", 32'(rx_done), 32'h0);
    repeat (10 * BIT_CLK) @(negedge clk);
    checkOutput("t5_no_done", 32'(done_cnt - base_done), 32'd0);
    applyStimulus(8'hC8, 1'b1, bm);
    repeat (4) @(negedge clk);
    checkOutput("t5_next_count", 32'(done_cnt - base_done), 32'd1);
    checkOutput("t5_next_data", 32'(last_data), 32'hC8);

    // 6. Loopback from a tick-driven transmitter
    base_done = done_cnt;
    base_fe   = fe_cnt;
    sendLoopback(8'h81);
    repeat (BIT_CLK) @(negedge clk);
    checkOutput("t6_done_count", 32'(done_cnt - base_done), 32'd1);
    checkOutput("t6_rx_data", 32'(last_data), 32'h81);
    checkOutput("t6_frame_err", 32'(fe_cnt - base_fe), 32'd0);

    // 7. Random bytes with random idle gaps (including none)
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 100));
      repeat (gap) @(negedge clk);
      base_done = done_cnt;
      applyStimulus(b, 1'b1, bm);
      checkOutput($sformatf("rand%0d_count", k), 32'(done_cnt - base_done), 32'd1);
      checkOutput($sformatf("rand%0d_data", k), 32'(last_data), 32'(expectedByte(b)));
    end
    repeat (8) @(negedge clk);
    checkOutput("final_busy", 32'(rx_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_cnt, fail_cnt);
    $finish;
  end

endmodule
